// File: rtl/dldo_pkg.sv
// Shared types and helpers for the digital-LDO thermometer loop controller.
package dldo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCK   = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int code_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dldo_tick_gen.sv
// Update-rate divider: one tick every div_sel+1 cycles, held at zero while clear is high.
module dldo_tick_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div_sel,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;

    // The period is sampled only at a wrap so a div_sel change never truncates a running interval.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            period <= '0;
        end else if (clear || (cnt == period)) begin
            cnt    <= '0;
            period <= div_sel;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == period);

endmodule

// File: rtl/dldo_thermo_ctrl.sv
// Digital-LDO loop controller driving an active-low thermometer pass-device bank.
// Build option: define DLDO_LOCK_FREEZE_EN to freeze the code in LOCK instead of rippling by one step.
module dldo_thermo_ctrl
    import dldo_pkg::*;
#(
    parameter int PASS_NUM = 10,
    parameter int STEP_MAX = 4,
    parameter int DIV_W    = 4,
    parameter int LC_CNT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            comp_in,
    input  logic [DIV_W-1:0]                div_sel,
    input  logic [$clog2(STEP_MAX+1)-1:0]   coarse_step,
    output logic [PASS_NUM-1:0]             out,
    output logic [code_w(PASS_NUM)-1:0]     code,
    output logic                            sat_hi,
    output logic                            sat_lo,
    output logic                            settled
);

    localparam int CW = code_w(PASS_NUM);
    localparam int SW = $clog2(STEP_MAX + 1);
    localparam int LW = code_w(LC_CNT);

    state_t          state, state_nxt;
    logic [CW-1:0]   code_nxt;
    logic [LW-1:0]   run, run_nxt, alt, alt_nxt;
    logic            last_dir, last_dir_nxt;
    logic            comp_meta, comp_sync, dir, reversal, tick;
    logic [SW-1:0]   step_eff;
    logic [PASS_NUM-1:0] out_nxt;

    function automatic logic [CW-1:0] move(input logic [CW-1:0] c, input logic up,
                                           input logic [SW-1:0] s);
        logic [CW:0] wide;
        if (up == DIR_UP) begin
            wide = {1'b0, c} + (CW+1)'(s);
            if (wide > (CW+1)'(PASS_NUM)) wide = (CW+1)'(PASS_NUM);
        end else begin
            wide = ({1'b0, c} >= (CW+1)'(s)) ? ({1'b0, c} - (CW+1)'(s)) : '0;
        end
        return wide[CW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            comp_meta <= 1'b1;
            comp_sync <= 1'b1;
        end else begin
            comp_meta <= comp_in;
            comp_sync <= comp_meta;
        end
    end

    assign dir      = ~comp_sync;
    assign reversal = (dir != last_dir);
    assign step_eff = (coarse_step == '0) ? SW'(1) :
                      (coarse_step > SW'(STEP_MAX)) ? SW'(STEP_MAX) : coarse_step;

    dldo_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .div_sel (div_sel),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            code     <= '0;
            last_dir <= DIR_DN;
            run      <= '0;
            alt      <= '0;
            out      <= '1;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b1;
            settled  <= 1'b0;
        end else begin
            state    <= state_nxt;
            code     <= code_nxt;
            last_dir <= last_dir_nxt;
            run      <= run_nxt;
            alt      <= alt_nxt;
            out      <= out_nxt;
            sat_hi   <= (code_nxt == CW'(PASS_NUM));
            sat_lo   <= (code_nxt == '0);
            settled  <= (state_nxt == LOCK);
        end
    end

    // Leaving IDLE adopts the current direction so the first coarse tick is not mistaken for a reversal.
    always_comb begin
        state_nxt    = state;
        code_nxt     = code;
        last_dir_nxt = last_dir;
        run_nxt      = run;
        alt_nxt      = alt;
        if (!en) begin
            state_nxt = IDLE;
            run_nxt   = '0;
            alt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = COARSE;
                    last_dir_nxt = dir;
                end
                COARSE: if (tick) begin
                    code_nxt     = move(code, dir, step_eff);
                    last_dir_nxt = dir;
                    if (reversal) begin
                        state_nxt = FINE;
                        run_nxt   = '0;
                        alt_nxt   = '0;
                    end
                end
                FINE: if (tick) begin
                    code_nxt     = move(code, dir, SW'(1));
                    last_dir_nxt = dir;
                    if (reversal) begin
                        alt_nxt = alt + 1'b1;
                        run_nxt = '0;
                    end else begin
                        run_nxt = run + 1'b1;
                        alt_nxt = '0;
                    end
                    if (alt_nxt == LW'(LC_CNT)) begin
                        state_nxt = LOCK;
                        run_nxt   = '0;
                        alt_nxt   = '0;
                    end else if (run_nxt == LW'(LC_CNT)) begin
                        state_nxt = COARSE;
                        run_nxt   = '0;
                        alt_nxt   = '0;
                    end
                end
                LOCK: if (tick) begin
                    last_dir_nxt = dir;
                    alt_nxt      = '0;
                    run_nxt      = reversal ? '0 : run + 1'b1;
`ifdef DLDO_LOCK_FREEZE_EN
                    if (run_nxt == LW'(LC_CNT)) begin
                        code_nxt  = move(code, dir, SW'(1));
                        state_nxt = FINE;
                        run_nxt   = '0;
                    end
`else
                    code_nxt = move(code, dir, SW'(1));
                    if (run_nxt == LW'(1)) begin
                        state_nxt = FINE;
                        run_nxt   = '0;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_nxt = '1;
        for (int i = 0; i < PASS_NUM; i++) out_nxt[i] = (i >= int'(code_nxt));
    end

endmodule
